// File: rtl/axi_wr_dma_nch.sv
// N-channel stream-to-DDR write engine for the AXI HP port.
// Round-robin over per-channel FWFT FIFOs; one 16-beat INCR burst in flight.
module axi_wr_dma_nch #(
    parameter int CH      = 4,
    parameter int FIFO_AW = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH*32-1:0] s_data,
    input  logic [CH-1:0]    s_valid,
    output logic [CH-1:0]    s_ready,
    input  logic [CH-1:0]    en,
    input  logic [CH*32-1:0] base,
    input  logic [CH*18-1:0] size,
    output logic [CH*18-1:0] acnt,
    output logic [CH*32-1:0] bcnt,
    output logic [CH-1:0]    err,
    input  logic [CH-1:0]    err_clr,
    output logic [31:0]      AXI_awaddr,
    output logic [3:0]       AXI_awlen,
    output logic [2:0]       AXI_awsize,
    output logic [1:0]       AXI_awburst,
    output logic [5:0]       AXI_awid,
    output logic [3:0]       AXI_awcache,
    output logic             AXI_awvalid,
    input  logic             AXI_awready,
    output logic [31:0]      AXI_wdata,
    output logic [3:0]       AXI_wstrb,
    output logic [5:0]       AXI_wid,
    output logic             AXI_wlast,
    output logic             AXI_wvalid,
    input  logic             AXI_wready,
    input  logic [5:0]       AXI_bid,
    input  logic [1:0]       AXI_bresp,
    input  logic             AXI_bvalid,
    output logic             AXI_bready
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int GW    = (CH > 1) ? $clog2(CH) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_AW, S_W, S_B} state_t;

    state_t         r_st;
    logic [GW-1:0]  r_g, r_last;
    logic [17:0]    r_size;
    logic [3:0]     r_beat;
    logic           r_awvalid, r_wvalid, r_wlast, r_bready;
    logic [31:0]    r_awaddr;
    logic [17:0]    r_acnt [CH];
    logic [31:0]    r_bcnt [CH];
    logic [CH-1:0]  r_err;

    logic [CH-1:0]  w_elig;
    logic [31:0]    w_head [CH];
    logic [GW-1:0]  w_gnt;
    logic           w_any;
    logic [31:0]    w_base;
    logic [17:0]    w_size, w_a0, w_inc;
    logic           w_unused;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [31:0]        r_mem [DEPTH];
        logic [FIFO_AW-1:0] r_wp, r_rp;
        logic [FIFO_AW:0]   r_cnt;
        logic               w_push, w_pop;

        assign s_ready[c] = en[c] & (r_cnt != (FIFO_AW+1)'(DEPTH)) & ~rst;
        assign w_push     = s_valid[c] & s_ready[c];
        assign w_pop      = r_wvalid & AXI_wready & (r_g == GW'(c));
        assign w_head[c]  = r_mem[r_rp];
        assign w_elig[c]  = en[c] && (size[c*18 +: 18] != 18'd0)
                            && (r_cnt >= (FIFO_AW+1)'(16));
        assign acnt[c*18 +: 18] = r_acnt[c];
        assign bcnt[c*32 +: 32] = r_bcnt[c];

        always_ff @(posedge clk) begin
            if (w_push) r_mem[r_wp] <= s_data[c*32 +: 32];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push) r_wp <= r_wp + 1'b1;
                if (w_pop)  r_rp <= r_rp + 1'b1;
                if (w_push && !w_pop)
                    r_cnt <= r_cnt + 1'b1;
                else if (!w_push && w_pop)
                    r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Walk downward so the nearest channel after last_grant wins.
    always_comb begin
        w_gnt = r_last;
        w_any = 1'b0;
        for (int i = CH; i >= 1; i--) begin
            if (w_elig[GW'((int'(r_last) + i) % CH)]) begin
                w_gnt = GW'((int'(r_last) + i) % CH);
                w_any = 1'b1;
            end
        end
    end

    assign w_base   = base[int'(w_gnt)*32 +: 32];
    assign w_size   = size[int'(w_gnt)*18 +: 18];
    assign w_a0     = (r_acnt[w_gnt] >= w_size) ? 18'd0 : r_acnt[w_gnt];
    assign w_inc    = r_acnt[r_g] + 18'd1;
    assign w_unused = ^{w_base[5:0], AXI_bid};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st      <= S_IDLE;
            r_g       <= '0;
            r_last    <= GW'(CH - 1);
            r_size    <= '0;
            r_beat    <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_wlast   <= 1'b0;
            r_bready  <= 1'b0;
            r_awaddr  <= '0;
            r_err     <= '0;
            for (int c = 0; c < CH; c++) begin
                r_acnt[c] <= '0;
                r_bcnt[c] <= '0;
            end
        end else begin
            r_err <= r_err & ~err_clr;
            unique case (r_st)
                S_IDLE: if (|w_elig) r_st <= S_ARB;
                S_ARB: begin
                    if (w_any) begin
                        r_g           <= w_gnt;
                        r_size        <= w_size;
                        r_acnt[w_gnt] <= w_a0;
                        r_awaddr      <= {w_base[31:6], 6'b0} + {8'b0, w_a0, 6'b0};
                        r_awvalid     <= 1'b1;
                        r_st          <= S_AW;
                    end else begin
                        r_st <= S_IDLE;
                    end
                end
                S_AW: if (AXI_awready) begin
                    r_awvalid <= 1'b0;
                    r_wvalid  <= 1'b1;
                    r_wlast   <= 1'b0;
                    r_beat    <= '0;
                    r_st      <= S_W;
                end
                S_W: if (AXI_wready) begin
                    r_beat  <= r_beat + 4'd1;
                    r_wlast <= (r_beat == 4'd14);
                    if (r_wlast) begin
                        r_wvalid <= 1'b0;
                        r_wlast  <= 1'b0;
                        r_bready <= 1'b1;
                        r_st     <= S_B;
                    end
                end
                S_B: if (AXI_bvalid) begin
                    r_acnt[r_g] <= (w_inc == r_size) ? 18'd0 : w_inc;
                    r_bcnt[r_g] <= r_bcnt[r_g] + 32'd1;
                    if (AXI_bresp != 2'b00) r_err[r_g] <= 1'b1;
                    r_last   <= r_g;
                    r_bready <= 1'b0;
                    r_st     <= S_IDLE;
                end
                default: r_st <= S_IDLE;
            endcase
        end
    end

    assign err         = r_err;
    assign AXI_awaddr  = r_awaddr;
    assign AXI_awlen   = 4'd15;
    assign AXI_awsize  = 3'd2;
    assign AXI_awburst = 2'b01;
    assign AXI_awcache = 4'b0011;
    assign AXI_awid    = 6'(r_g);
    assign AXI_awvalid = r_awvalid;
    assign AXI_wdata   = w_head[r_g];
    assign AXI_wstrb   = 4'hF;
    assign AXI_wid     = 6'(r_g);
    assign AXI_wlast   = r_wlast;
    assign AXI_wvalid  = r_wvalid;
    assign AXI_bready  = r_bready;
endmodule

// File: tb/tb_axi_wr_dma_nch.sv
// Directed bench for axi_wr_dma_nch: bursts, round-robin, backpressure,
// FIFO full/disable, error flag, size shrink and async reset.
module tb_axi_wr_dma_nch;
    localparam int CH  = 4;
    localparam int FAW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [CH*32-1:0] s_data, base;
    logic [CH-1:0]    s_valid, s_ready, en, err, err_clr;
    logic [CH*18-1:0] size, acnt;
    logic [CH*32-1:0] bcnt;
    logic [31:0]      AXI_awaddr, AXI_wdata;
    logic [3:0]       AXI_awlen, AXI_awcache, AXI_wstrb;
    logic [2:0]       AXI_awsize;
    logic [1:0]       AXI_awburst, AXI_bresp;
    logic [5:0]       AXI_awid, AXI_wid, AXI_bid;
    logic             AXI_awvalid, AXI_awready, AXI_wlast, AXI_wvalid;
    logic             AXI_wready, AXI_bvalid, AXI_bready;

    axi_wr_dma_nch #(.CH(CH), .FIFO_AW(FAW)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .en(en), .base(base), .size(size),
        .acnt(acnt), .bcnt(bcnt), .err(err), .err_clr(err_clr),
        .AXI_awaddr(AXI_awaddr), .AXI_awlen(AXI_awlen),
        .AXI_awsize(AXI_awsize), .AXI_awburst(AXI_awburst),
        .AXI_awid(AXI_awid), .AXI_awcache(AXI_awcache),
        .AXI_awvalid(AXI_awvalid), .AXI_awready(AXI_awready),
        .AXI_wdata(AXI_wdata), .AXI_wstrb(AXI_wstrb), .AXI_wid(AXI_wid),
        .AXI_wlast(AXI_wlast), .AXI_wvalid(AXI_wvalid),
        .AXI_wready(AXI_wready), .AXI_bid(AXI_bid), .AXI_bresp(AXI_bresp),
        .AXI_bvalid(AXI_bvalid), .AXI_bready(AXI_bready)
    );

    int n_tot = 0, n_pass = 0, n_fail = 0;
    logic [31:0] q_addr[$], q_wd[$];
    logic [5:0]  q_awid[$], q_wid[$];
    logic        q_wl[$];
    logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_wl = 0;
    logic [31:0] p_addr = 0, p_wd = 0;
    logic        rnd_done;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bc(input int c);
        return bcnt[c*32 +: 32];
    endfunction

    function automatic logic [31:0] ac(input int c);
        return 32'(acnt[c*18 +: 18]);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            p_awv = 0;
            p_wv  = 0;
        end else begin
            if (p_awv && !p_awr) begin
                chk("aw_hold_v", 32'(AXI_awvalid), 1);
                chk("aw_hold_a", AXI_awaddr, p_addr);
            end
            if (p_wv && !p_wr) begin
                chk("w_hold_v", 32'(AXI_wvalid), 1);
                chk("w_hold_d", AXI_wdata, p_wd);
                chk("w_hold_l", 32'(AXI_wlast), 32'(p_wl));
            end
            if (AXI_awvalid && AXI_awready) begin
                q_addr.push_back(AXI_awaddr);
                q_awid.push_back(AXI_awid);
            end
            if (AXI_wvalid && AXI_wready) begin
                q_wd.push_back(AXI_wdata);
                q_wid.push_back(AXI_wid);
                q_wl.push_back(AXI_wlast);
            end
            p_awv  = AXI_awvalid;
            p_awr  = AXI_awready;
            p_addr = AXI_awaddr;
            p_wv   = AXI_wvalid;
            p_wr   = AXI_wready;
            p_wd   = AXI_wdata;
            p_wl   = AXI_wlast;
        end
    end

    task automatic clrq();
        q_addr.delete(); q_awid.delete();
        q_wd.delete(); q_wid.delete(); q_wl.delete();
    endtask

    task automatic do_reset();
        rst = 1; en = '0; s_valid = '0; err_clr = '0;
        AXI_awready = 0; AXI_wready = 0; AXI_bvalid = 1; AXI_bresp = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        clrq();
    endtask

    task automatic push(input int c, input int n, input int v0);
        int k = 0, g = 0;
        logic hs;
        while (k < n && g < 3000) begin
            s_valid[c] = 1;
            s_data[c*32 +: 32] = 32'(v0 + k);
            @(negedge clk);
            hs = s_ready[c];
            @(posedge clk);
            #1;
            if (hs) k++;
            g++;
        end
        s_valid[c] = 0;
        chk("push_done", 32'(k), 32'(n));
    endtask

    task automatic wait_bcnt(input int c, input int n, input string tag);
        int t = 0;
        while (bc(c) < 32'(n) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk(tag, bc(c), 32'(n));
    endtask

    initial begin
        int acc, seen, t, k0, k1, m;
        rst = 1; en = '1; s_valid = '0; s_data = '0; base = '0; size = '0;
        err_clr = '0; AXI_awready = 0; AXI_wready = 0; AXI_bvalid = 0;
        AXI_bresp = 0; AXI_bid = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_sready", 32'(s_ready), 0);
        chk("rst_awvalid", 32'(AXI_awvalid), 0);
        chk("rst_wvalid", 32'(AXI_wvalid), 0);
        chk("rst_wlast", 32'(AXI_wlast), 0);
        chk("rst_bready", 32'(AXI_bready), 0);
        chk("rst_acnt", 32'(|acnt), 0);
        chk("rst_bcnt", 32'(|bcnt), 0);
        chk("rst_err", 32'(err), 0);

        // single channel, four bursts with ring wrap
        do_reset();
        en[0] = 1; base[31:0] = 32'h1000_0000; size[17:0] = 18'd4;
        AXI_awready = 1; AXI_wready = 1;
        push(0, 64, 0);
        wait_bcnt(0, 4, "t1_bcnt");
        chk("t1_acnt", ac(0), 0);
        chk("t1_naw", q_addr.size(), 4);
        for (int j = 0; j < q_addr.size(); j++) begin
            chk("t1_addr", q_addr[j], 32'h1000_0000 + 32'(j * 64));
            chk("t1_awid", 32'(q_awid[j]), 0);
        end
        chk("t1_nbeat", q_wd.size(), 64);
        for (int k = 0; k < q_wd.size(); k++) begin
            chk("t1_wdata", q_wd[k], 32'(k));
            chk("t1_wlast", 32'(q_wl[k]), 32'(k % 16 == 15));
        end

        // round-robin over four prefilled channels
        do_reset();
        for (int c = 0; c < CH; c++) begin
            base[c*32 +: 32] = 32'h2000_0000 + 32'(c) * 32'h0100_0000;
            size[c*18 +: 18] = 18'd8;
        end
        en = '1;
        for (int c = 0; c < CH; c++) push(c, 32, c * 256);
        AXI_awready = 1; AXI_wready = 1;
        wait_bcnt(3, 2, "rr_bcnt3");
        for (int c = 0; c < 3; c++) chk("rr_bcnt", bc(c), 2);
        chk("rr_naw", q_addr.size(), 8);
        for (int j = 0; j < q_addr.size(); j++) begin
            chk("rr_awid", 32'(q_awid[j]), 32'(j % 4));
            chk("rr_addr", q_addr[j], 32'h2000_0000
                + 32'(j % 4) * 32'h0100_0000 + 32'((j / 4) * 64));
        end
        chk("rr_nbeat", q_wd.size(), 128);
        for (int k = 0; k < q_wd.size(); k++) begin
            m = k / 16;
            chk("rr_wid", 32'(q_wid[k]), 32'(m % 4));
            chk("rr_wdata", q_wd[k],
                32'((m % 4) * 256 + (m / 4) * 16 + k % 16));
        end

        // random backpressure on two channels
        do_reset();
        base[31:0] = 32'h3000_0000; size[17:0] = 18'd2;
        base[63:32] = 32'h3100_0000; size[35:18] = 18'd2;
        en[1:0] = 2'b11;
        rnd_done = 0;
        fork
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    if (!rnd_done) begin
                        AXI_awready = 1'($urandom_range(0, 1));
                        AXI_wready  = 1'($urandom_range(0, 1));
                    end
                end
            end
        join_none
        fork
            push(0, 48, 0);
            push(1, 48, 256);
        join
        wait_bcnt(0, 3, "bp_bcnt0");
        wait_bcnt(1, 3, "bp_bcnt1");
        rnd_done = 1;
        repeat (2) @(posedge clk);
        #1 AXI_awready = 1; AXI_wready = 1;
        chk("bp_nbeat", q_wd.size(), 96);
        chk("bp_beats_vs_bcnt", q_wd.size(), 16 * (bc(0) + bc(1)));
        chk("bp_acnt0", ac(0), 1);
        k0 = 0; k1 = 0;
        for (int k = 0; k < q_wd.size(); k++) begin
            if (q_wid[k] == 6'd0) begin
                chk("bp_wdata0", q_wd[k], 32'(k0));
                chk("bp_wlast0", 32'(q_wl[k]), 32'(k0 % 16 == 15));
                k0++;
            end else begin
                chk("bp_wid1", 32'(q_wid[k]), 1);
                chk("bp_wdata1", q_wd[k], 32'(256 + k1));
                chk("bp_wlast1", 32'(q_wl[k]), 32'(k1 % 16 == 15));
                k1++;
            end
        end
        k0 = 0;
        for (int j = 0; j < q_addr.size(); j++) begin
            if (q_awid[j] == 6'd0) begin
                chk("bp_addr0", q_addr[j], 32'h3000_0000 + 32'((k0 % 2) * 64));
                k0++;
            end
        end
        chk("bp_naw0", 32'(k0), 3);

        // FIFO full with AW stalled
        do_reset();
        base[95:64] = 32'h4000_0000; size[53:36] = 18'd4;
        en[2] = 1;
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            s_valid[2] = 1;
            s_data[95:64] = 32'(i);
            @(negedge clk);
            if (s_ready[2]) acc++;
            @(posedge clk);
            #1;
        end
        s_valid[2] = 0;
        chk("full_acc", 32'(acc), 32);
        @(negedge clk);
        chk("full_sready", 32'(s_ready[2]), 0);

        // disabled channel holding 16 words issues nothing
        do_reset();
        base[127:96] = 32'h4800_0000; size[71:54] = 18'd4;
        en[3] = 1;
        push(3, 16, 32'h500);
        en[3] = 0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (AXI_awvalid) seen++;
        end
        chk("dis_noaw", 32'(seen), 0);
        @(posedge clk);
        #1 en[3] = 1;
        @(negedge clk);
        chk("lat_c0", 32'(AXI_awvalid), 0);
        @(negedge clk);
        chk("lat_c1", 32'(AXI_awvalid), 0);
        @(negedge clk);
        chk("lat_c2", 32'(AXI_awvalid), 1);
        chk("dis_addr", AXI_awaddr, 32'h4800_0000);
        chk("dis_awid", 32'(AXI_awid), 3);
        chk("fix_fields", {AXI_awlen, 1'b0, AXI_awsize, 2'b0, AXI_awburst,
                           AXI_awcache, AXI_wstrb, 12'h0},
            {4'hF, 1'b0, 3'd2, 2'b0, 2'b01, 4'h3, 4'hF, 12'h0});
        @(posedge clk);
        #1 AXI_awready = 1; AXI_wready = 1;
        wait_bcnt(3, 1, "dis_bcnt");
        chk("dis_nbeat", q_wd.size(), 16);
        for (int k = 0; k < q_wd.size(); k++)
            chk("dis_wdata", q_wd[k], 32'h500 + 32'(k));

        // error flag: set, clear, set-wins-over-clear
        do_reset();
        base[31:0] = 32'h5000_0000; size[17:0] = 18'd4;
        en[0] = 1; AXI_awready = 1; AXI_wready = 1;
        push(0, 16, 0);
        wait_bcnt(0, 1, "err_b1");
        chk("err_ok", 32'(err[0]), 0);
        AXI_bresp = 2'b10;
        push(0, 16, 16);
        wait_bcnt(0, 2, "err_b2");
        AXI_bresp = 2'b00;
        chk("err_set", 32'(err[0]), 1);
        @(posedge clk);
        #1 err_clr[0] = 1;
        @(posedge clk);
        #1 err_clr[0] = 0;
        chk("err_clr", 32'(err[0]), 0);
        AXI_bresp = 2'b10;
        push(0, 16, 32);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!AXI_bready && t < 200);
        chk("err_bready", 32'(AXI_bready), 1);
        err_clr[0] = 1;
        @(posedge clk);
        #1 err_clr[0] = 0;
        AXI_bresp = 2'b00;
        chk("err_setwins", 32'(err[0]), 1);
        chk("err_bcnt3", bc(0), 3);

        // size shrink while acnt=5
        do_reset();
        base[31:0] = 32'h6000_0000; size[17:0] = 18'd8;
        en[0] = 1; AXI_awready = 1; AXI_wready = 1;
        push(0, 80, 0);
        wait_bcnt(0, 5, "shr_b5");
        chk("shr_acnt5", ac(0), 5);
        size[17:0] = 18'd2;
        clrq();
        push(0, 16, 80);
        wait_bcnt(0, 6, "shr_b6");
        chk("shr_naw", q_addr.size(), 1);
        chk("shr_addr", q_addr[0], 32'h6000_0000);
        chk("shr_acnt", ac(0), 1);

        // asynchronous reset in the middle of W
        AXI_wready = 0;
        push(0, 16, 96);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!AXI_wvalid && t < 200);
        chk("rstw_wvalid_pre", 32'(AXI_wvalid), 1);
        #2 rst = 1;
        #1;
        chk("rstw_wvalid", 32'(AXI_wvalid), 0);
        chk("rstw_awvalid", 32'(AXI_awvalid), 0);
        chk("rstw_bready", 32'(AXI_bready), 0);
        chk("rstw_bcnt", bc(0), 0);
        chk("rstw_acnt", ac(0), 0);
        chk("rstw_sready", 32'(s_ready), 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        clrq();
        AXI_wready = 1;
        push(0, 15, 32'h900);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (AXI_awvalid) seen++;
        end
        chk("rstw_empty", 32'(seen), 0);
        push(0, 1, 32'h90F);
        wait_bcnt(0, 1, "rstw_b1");
        chk("rstw_addr", q_addr.size() > 0 ? q_addr[0] : 32'hDEAD, 32'h6000_0000);
        chk("rstw_nbeat", q_wd.size(), 16);
        for (int k = 0; k < q_wd.size(); k++)
            chk("rstw_wdata", q_wd[k], 32'h900 + 32'(k));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/axi_wr_dma_nch.md
# axi_wr_dma_nch

N-channel stream-to-memory write engine for the Zynq AXI HP slave port. It is the multi-channel successor of the single-stream AXI write path. Each channel owns a word FIFO, a ring buffer in DDR (base/size), and address/burst counters. Channels are serviced by a round-robin arbiter that issues fixed 16-beat INCR bursts. It sits between the sample-stream sources (already in the AXI clock domain) and S_AXI_HP0, with its per-channel control and status mapped through the register-space block.

## Interface

- CH, 4: channel count, 1..8
- FIFO_AW, 6: log2 of per-channel FIFO depth in 32-bit words; must be at least 5 (32 words)
- clk  in  1  AXI clock (FCLK_CLK1 domain); the only clock
- rst  in  1  asynchronous, active-high reset
- s_data  in  CH*32  stream words; channel c uses [32c+31:32c]
- s_valid  in  CH  word valid per channel
- s_ready  out  CH  word accepted when s_valid & s_ready
- en  in  CH  channel enable
- base  in  CH*32  ring base byte address; bits [5:0] are ignored (treated as 0)
- size  in  CH*18  ring size in 64-byte units (register bits [23:6])
- acnt  out  CH*18  current ring offset in 64-byte units
- bcnt  out  CH*32  completed burst count, wraps modulo 2^32
- err  out  CH  sticky flag: a non-OKAY bresp was received
- err_clr  in  CH  one-cycle pulse clears err
- AXI_awaddr 32, AXI_awlen 4, AXI_awsize 3, AXI_awburst 2, AXI_awid 6, AXI_awcache 4, AXI_awvalid 1  out
- AXI_awready  in  1
- AXI_wdata 32, AXI_wstrb 4, AXI_wid 6, AXI_wlast 1, AXI_wvalid 1  out
- AXI_wready  in  1
- AXI_bid 6, AXI_bresp 2, AXI_bvalid 1  in
- AXI_bready  out  1

## Operation

**Per-channel FIFO**
- First-word-fall-through FIFO.
- s_ready = en[c] & !full.
- A push and a pop in the same cycle leave the occupancy unchanged.
- Deasserting en only blocks pushes and arbitration. FIFO contents are retained.

**Eligibility**
- A channel is eligible when en=1, size≠0 and occupancy ≥ 16.

**Fixed AXI fields**
- awlen=15, awsize=2, awburst=INCR (01), awcache=4'b0011, wstrb=4'hF.
- awid = wid = channel index.

**Burst length and outstanding bursts**
- Every burst is exactly 16 beats (64 bytes).
- Only one burst is in flight at a time.

**State machine**
- IDLE → ARB when any channel is eligible.
- ARB (1 cycle):
  - Grant goes to the first eligible channel, searching from last_grant+1 modulo CH.
  - base[g] and size[g] are latched.
  - If acnt[g] ≥ the latched size, acnt[g] is set to 0.
- AW:
  - awvalid=1, awaddr = {base[31:6],6'b0} + acnt×64.
  - On awready → W.
- W:
  - wvalid=1, wdata = head of the granted channel's FIFO.
  - The FIFO pops on each wvalid&wready.
  - wlast is asserted on beat 16; its handshake → B.
- B:
  - bready=1.
  - On bvalid:
    - acnt = (acnt+1 = size) ? 0 : acnt+1.
    - bcnt += 1.
    - If bresp ≠ 00, err[g] is set.
  - last_grant = g, then → IDLE.

**Channel changes mid-burst**
- Deasserting en, or changing base/size, during AW/W/B does not abort the burst.
- New base/size values take effect at the next ARB for that channel.

**err flag**
- If err_clr[c] coincides with an error on channel c, the set wins.

**Reset**
- FIFOs are emptied and all counters, flags and the FSM go to 0/IDLE.
- last_grant = CH-1, so channel 0 has first priority.

## Timing

**Output values during and after reset**
- All outputs are 0 during reset: awvalid, wvalid, wlast, bready, acnt, bcnt, err and s_ready.
- After reset, s_ready follows en and FIFO full combinationally from registered state.

**Latency**
- Eligibility reached (cycle 0) → ARB at cycle 1 → awvalid at cycle 2.
- The pushed 16th word counts toward eligibility in the cycle after its handshake.
- wvalid rises in the cycle after the AW handshake.
- Beats stream one per cycle while wready=1. Stalls hold wdata and wlast stable.
- acnt, bcnt and err update in the cycle after the B handshake.

**Holding rules**
- awvalid, once asserted, stays high with a stable awaddr until awready.
- wvalid stays high until the beat is accepted.

**Wrap-around and asynchronous events**
- acnt wraps from size-1 to 0; the wrapped burst goes to base.
- bcnt wraps from 0xFFFFFFFF to 0.
- Asynchronous rst mid-burst:
  - Outputs drop immediately and the FSM returns to IDLE.
  - Interconnect recovery is the system's responsibility.

## Test plan

- **Single channel, basic bursts.** CH=1, base=0x1000_0000, size=4, push 64 words 0..63, awready=wready=bvalid=1.
  - 4 bursts at 0x1000_0000, 0x1000_0040, 0x1000_0080, 0x1000_00C0.
  - wdata is in order and wlast is on every 16th beat.
  - Final acnt=0 (wrapped), bcnt=4.
- **Round-robin.** 4 channels, each prefilled with 32 words.
  - Grant order is 0,1,2,3,0,1,2,3.
  - awid matches the channel; each channel ends with bcnt=2.
- **Backpressure.** Random wready/awready with 50% duty.
  - No beat is lost or duplicated.
  - awaddr and wdata stay stable while their valid is high and ready is low.
  - Total beats = 16 × bcnt.
- **FIFO full and disable.** FIFO_AW=5, no awready, push 40 words.
  - s_ready drops after 32 words accepted.
  - With en=0 and 16 words in the FIFO, no AW is issued.
- **Error handling.** bresp=2'b10 on the second burst.
  - err=1 and bcnt still increments.
  - An err_clr pulse clears err; with err_clr coinciding with a new error, err stays 1.
- **Size shrink and reset.** Size shrinks from 8 to 2 while acnt=5.
  - The next burst goes to base (acnt reset to 0).
  - Asserting rst during W: wvalid=0 in the same cycle, all counters 0, FIFOs empty.
